// File: rtl/dma_reg_file_if.sv
// Register bus between the DMA bus interface (master) and the register file (slave).
interface dma_reg_file_if #(
    parameter int ADDR_WIDTH = 8,
    parameter int DATA_WIDTH = 32
);
    logic                  wr_en;
    logic                  rd_en;
    logic [ADDR_WIDTH-1:0] addr;
    logic [DATA_WIDTH-1:0] wdata;
    logic [DATA_WIDTH-1:0] rdata;

    modport master (output wr_en, rd_en, addr, wdata, input rdata);
    modport slave  (input wr_en, rd_en, addr, wdata, output rdata);
endinterface

// File: rtl/dma_reg_file.sv
// DMA channel register bank plus transfer countdown engine (IDLE -> BUSY -> DONE).
module dma_reg_file #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 8,
    parameter int SIZE_WIDTH = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    dma_reg_file_if.slave         bus,
    input  logic                  xfer_ack,
    output logic                  xfer_req,
    output logic [DATA_WIDTH-1:0] src_addr_o,
    output logic [DATA_WIDTH-1:0] dst_addr_o,
    output logic                  irq
);
    localparam logic [ADDR_WIDTH-1:0] A_CTRL   = ADDR_WIDTH'('h00);
    localparam logic [ADDR_WIDTH-1:0] A_STATUS = ADDR_WIDTH'('h04);
    localparam logic [ADDR_WIDTH-1:0] A_SRC    = ADDR_WIDTH'('h08);
    localparam logic [ADDR_WIDTH-1:0] A_DST    = ADDR_WIDTH'('h0C);
    localparam logic [ADDR_WIDTH-1:0] A_SIZE   = ADDR_WIDTH'('h10);
    localparam logic [ADDR_WIDTH-1:0] A_INTR   = ADDR_WIDTH'('h14);
    localparam logic [ADDR_WIDTH-1:0] A_REMAIN = ADDR_WIDTH'('h18);

    typedef enum logic [1:0] {S_IDLE, S_BUSY, S_DONE} state_t;

    state_t                state, state_nxt;
    logic                  intr_en;
    logic [DATA_WIDTH-1:0] src_addr, dst_addr;
    logic [SIZE_WIDTH-1:0] trans_size, remain;
    logic                  done_f, err_f;
    logic [1:0]            intr_stat;
    logic [DATA_WIDTH-1:0] rd_mux;

    logic [ADDR_WIDTH-1:0] waddr;
    logic wr_ctrl, wr_src, wr_dst, wr_size, wr_intr;
    logic start_req, abort_req;
    logic load, zero_err, abort_err, beat, set_done;

    // Word-aligned decode; the byte offset bits are masked off.
    assign waddr   = bus.addr & ~ADDR_WIDTH'(3);
    assign wr_ctrl = bus.wr_en && (waddr == A_CTRL);
    assign wr_src  = bus.wr_en && (waddr == A_SRC);
    assign wr_dst  = bus.wr_en && (waddr == A_DST);
    assign wr_size = bus.wr_en && (waddr == A_SIZE);
    assign wr_intr = bus.wr_en && (waddr == A_INTR);

    // ABORT outranks START when both are written together.
    assign start_req = wr_ctrl && bus.wdata[0] && !bus.wdata[2];
    assign abort_req = wr_ctrl && bus.wdata[2];

    assign src_addr_o = src_addr;
    assign dst_addr_o = dst_addr;

    // State register.
    always_ff @(posedge clk) begin
        if (rst) state <= S_IDLE;
        else     state <= state_nxt;
    end

    // Next-state logic.
    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE: if (start_req && trans_size != '0) state_nxt = S_BUSY;
            S_BUSY: begin
                if (abort_req)                                    state_nxt = S_IDLE;
                else if (xfer_ack && remain == SIZE_WIDTH'(1))    state_nxt = S_DONE;
            end
            S_DONE: state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    // FSM outputs: request line and one-cycle event strobes for the datapath registers.
    always_comb begin
        xfer_req  = 1'b0;
        load      = 1'b0;
        zero_err  = 1'b0;
        abort_err = 1'b0;
        beat      = 1'b0;
        set_done  = 1'b0;
        case (state)
            S_IDLE: begin
                load     = start_req && (trans_size != '0);
                zero_err = start_req && (trans_size == '0);
            end
            S_BUSY: begin
                xfer_req  = 1'b1;
                abort_err = abort_req;
                beat      = xfer_ack && !abort_req;
            end
            S_DONE: set_done = 1'b1;
            default: ;
        endcase
    end

    // Channel configuration; address/size are frozen while a transfer runs.
    always_ff @(posedge clk) begin
        if (rst) begin
            intr_en    <= 1'b0;
            src_addr   <= '0;
            dst_addr   <= '0;
            trans_size <= '0;
        end else begin
            if (wr_ctrl)                     intr_en    <= bus.wdata[1];
            if (wr_src  && state != S_BUSY)  src_addr   <= bus.wdata;
            if (wr_dst  && state != S_BUSY)  dst_addr   <= bus.wdata;
            if (wr_size && state != S_BUSY)  trans_size <= bus.wdata[SIZE_WIDTH-1:0];
        end
    end

    // Beat counter and sticky status flags; any start attempt clears the previous DONE.
    always_ff @(posedge clk) begin
        if (rst) begin
            remain <= '0;
            done_f <= 1'b0;
            err_f  <= 1'b0;
        end else begin
            if (load) begin
                remain <= trans_size;
                done_f <= 1'b0;
                err_f  <= 1'b0;
            end else if (beat) begin
                remain <= remain - SIZE_WIDTH'(1);
            end
            if (zero_err) begin
                done_f <= 1'b0;
                err_f  <= 1'b1;
            end
            if (abort_err) err_f  <= 1'b1;
            if (set_done)  done_f <= 1'b1;
        end
    end

    // Interrupt status (W1C, hardware set wins) and registered interrupt line.
    always_ff @(posedge clk) begin
        if (rst) begin
            intr_stat <= '0;
            irq       <= 1'b0;
        end else begin
            intr_stat <= {zero_err | abort_err, set_done}
                       | (intr_stat & ~(wr_intr ? bus.wdata[1:0] : 2'b00));
            irq       <= intr_en && (|intr_stat);
        end
    end

    // Read mux; unmapped addresses return zero.
    always_comb begin
        rd_mux = '0;
        case (waddr)
            A_CTRL:   rd_mux[1]   = intr_en;
            A_STATUS: rd_mux[2:0] = {err_f, done_f, state == S_BUSY};
            A_SRC:    rd_mux      = src_addr;
            A_DST:    rd_mux      = dst_addr;
            A_SIZE:   rd_mux[SIZE_WIDTH-1:0] = trans_size;
            A_INTR:   rd_mux[1:0] = intr_stat;
            A_REMAIN: rd_mux[SIZE_WIDTH-1:0] = remain;
            default:  rd_mux      = '0;
        endcase
    end

    // Registered read data, held between reads; a same-cycle write is not yet visible.
    always_ff @(posedge clk) begin
        if (rst)             bus.rdata <= '0;
        else if (bus.rd_en)  bus.rdata <= rd_mux;
    end
endmodule

// File: tb/tb_dma_reg_file.sv
// Directed bench for dma_reg_file: register-map table plus transfer engine sequences.
module tb_dma_reg_file;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        xfer_ack = 1'b0;
    logic        xfer_req;
    logic        irq;
    logic [31:0] src_addr_o, dst_addr_o;

    dma_reg_file_if bus ();

    dma_reg_file dut (
        .clk        (clk),
        .rst        (rst),
        .bus        (bus),
        .xfer_ack   (xfer_ack),
        .xfer_req   (xfer_req),
        .src_addr_o (src_addr_o),
        .dst_addr_o (dst_addr_o),
        .irq        (irq)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic        wr;
        logic        rd;
        logic [7:0]  addr;
        logic [31:0] wdata;
        logic [31:0] exp;
    } vec_t;

    vec_t tbl[$];
    int total = 0;
    int bad   = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wr(input logic [7:0] a, input logic [31:0] d);
        bus.wr_en = 1'b1; bus.addr = a; bus.wdata = d;
        tick();
        bus.wr_en = 1'b0;
    endtask

    task automatic rd_chk(input string name, input logic [7:0] a, input logic [31:0] exp);
        bus.rd_en = 1'b1; bus.addr = a;
        tick();
        bus.rd_en = 1'b0;
        chk(name, bus.rdata, exp);
    endtask

    initial begin
        int n;
        int acks;
        bus.wr_en = 1'b0; bus.rd_en = 1'b0; bus.addr = '0; bus.wdata = '0;

        // ---- reset ----
        rst = 1'b1;
        repeat (2) tick();
        rst = 1'b0;
        chk("rst_rdata", bus.rdata, 32'h0);
        chk("rst_irq", {31'h0, irq}, 32'h0);
        chk("rst_req", {31'h0, xfer_req}, 32'h0);

        // ---- register map table ----
        tbl.push_back(vec_t'{1'b0, 1'b1, 8'h00, 32'h0, 32'h0});
        tbl.push_back(vec_t'{1'b0, 1'b1, 8'h04, 32'h0, 32'h0});
        tbl.push_back(vec_t'{1'b0, 1'b1, 8'h08, 32'h0, 32'h0});
        tbl.push_back(vec_t'{1'b0, 1'b1, 8'h0C, 32'h0, 32'h0});
        tbl.push_back(vec_t'{1'b0, 1'b1, 8'h10, 32'h0, 32'h0});
        tbl.push_back(vec_t'{1'b0, 1'b1, 8'h14, 32'h0, 32'h0});
        tbl.push_back(vec_t'{1'b0, 1'b1, 8'h18, 32'h0, 32'h0});
        tbl.push_back(vec_t'{1'b1, 1'b0, 8'h08, 32'h1000, 32'h0});
        tbl.push_back(vec_t'{1'b1, 1'b1, 8'h08, 32'h5555, 32'h1000});   // read sees old value
        tbl.push_back(vec_t'{1'b0, 1'b1, 8'h08, 32'h0, 32'h5555});
        tbl.push_back(vec_t'{1'b0, 1'b1, 8'h09, 32'h0, 32'h5555});      // byte offset ignored
        tbl.push_back(vec_t'{1'b1, 1'b0, 8'h08, 32'h1000, 32'h0});
        tbl.push_back(vec_t'{1'b1, 1'b0, 8'h0C, 32'h2000, 32'h0});
        tbl.push_back(vec_t'{1'b0, 1'b1, 8'h0C, 32'h0, 32'h2000});
        tbl.push_back(vec_t'{1'b1, 1'b0, 8'h10, 32'hABCD0004, 32'h0});
        tbl.push_back(vec_t'{1'b0, 1'b1, 8'h10, 32'h0, 32'h4});         // upper bits read 0
        tbl.push_back(vec_t'{1'b1, 1'b0, 8'h04, 32'hFFFFFFFF, 32'h0});
        tbl.push_back(vec_t'{1'b0, 1'b1, 8'h04, 32'h0, 32'h0});         // RO write ignored
        tbl.push_back(vec_t'{1'b1, 1'b0, 8'h18, 32'h0000FFFF, 32'h0});
        tbl.push_back(vec_t'{1'b0, 1'b1, 8'h18, 32'h0, 32'h0});
        tbl.push_back(vec_t'{1'b1, 1'b0, 8'h3C, 32'h1234, 32'h0});
        tbl.push_back(vec_t'{1'b0, 1'b1, 8'h3C, 32'h0, 32'h0});         // unmapped
        tbl.push_back(vec_t'{1'b1, 1'b0, 8'h00, 32'h2, 32'h0});
        tbl.push_back(vec_t'{1'b0, 1'b1, 8'h00, 32'h0, 32'h2});
        tbl.push_back(vec_t'{1'b1, 1'b0, 8'h14, 32'h3, 32'h0});
        tbl.push_back(vec_t'{1'b0, 1'b1, 8'h14, 32'h0, 32'h0});
        tbl.push_back(vec_t'{1'b0, 1'b1, 8'h08, 32'h0, 32'h1000});

        foreach (tbl[i]) begin
            bus.wr_en = tbl[i].wr; bus.rd_en = tbl[i].rd;
            bus.addr  = tbl[i].addr; bus.wdata = tbl[i].wdata;
            tick();
            bus.wr_en = 1'b0; bus.rd_en = 1'b0;
            if (tbl[i].rd) chk($sformatf("tbl[%0d]", i), bus.rdata, tbl[i].exp);
        end
        tick();
        chk("rd_hold", bus.rdata, 32'h1000);
        chk("src_mirror", src_addr_o, 32'h1000);
        chk("dst_mirror", dst_addr_o, 32'h2000);

        // ---- basic transfer, ack held high ----
        wr(8'h10, 32'd4);
        wr(8'h00, 32'h3);
        n = xfer_req ? 1 : 0;
        xfer_ack = 1'b1; bus.rd_en = 1'b1; bus.addr = 8'h18;
        for (int k = 1; k <= 6; k++) begin
            tick();
            if (xfer_req) n++;
            if (k == 2) chk("remain_3", bus.rdata, 32'd3);
            if (k == 3) chk("remain_2", bus.rdata, 32'd2);
            if (k == 4) chk("remain_1", bus.rdata, 32'd1);
            if (k == 4) chk("req_drop", {31'h0, xfer_req}, 32'h0);
        end
        xfer_ack = 1'b0; bus.rd_en = 1'b0;
        chk("req_cycles", n, 32'd4);
        chk("irq_done", {31'h0, irq}, 32'h1);
        rd_chk("status_done", 8'h04, 32'h2);
        rd_chk("intr_done", 8'h14, 32'h1);
        rd_chk("ctrl_rb", 8'h00, 32'h2);
        wr(8'h14, 32'h1);
        chk("irq_lag", {31'h0, irq}, 32'h1);
        tick();
        chk("irq_clr", {31'h0, irq}, 32'h0);

        // ---- paced transfer, config locked while busy ----
        wr(8'h10, 32'd3);
        wr(8'h00, 32'h3);
        acks = 0;
        for (int i = 1; i <= 6; i++) begin
            xfer_ack = (i % 2 == 1);
            if (i == 2) begin
                bus.wr_en = 1'b1; bus.addr = 8'h10; bus.wdata = 32'd9;
            end
            tick();
            if (xfer_ack) acks++;
            xfer_ack = 1'b0; bus.wr_en = 1'b0;
            chk($sformatf("paced_busy[%0d]", i), {31'h0, xfer_req}, {31'h0, acks < 3});
        end
        rd_chk("size_locked", 8'h10, 32'd3);
        rd_chk("paced_status", 8'h04, 32'h2);
        wr(8'h14, 32'h3);
        rd_chk("intr_cleared", 8'h14, 32'h0);

        // ---- W1C race with DONE set ----
        wr(8'h10, 32'd1);
        wr(8'h00, 32'h3);
        xfer_ack = 1'b1;
        tick();                      // last ack taken, engine now in DONE
        xfer_ack = 1'b0;
        wr(8'h14, 32'h1);            // clear lands on the same edge as the set
        rd_chk("w1c_race", 8'h14, 32'h1);
        wr(8'h14, 32'h3);

        // ---- zero size start ----
        wr(8'h10, 32'd0);
        wr(8'h00, 32'h3);
        n = 0;
        for (int i = 0; i < 4; i++) begin
            if (xfer_req) n++;
            tick();
        end
        chk("zero_no_req", n, 32'd0);
        rd_chk("zero_status", 8'h04, 32'h4);
        rd_chk("zero_intr", 8'h14, 32'h2);
        wr(8'h14, 32'h3);

        // ---- abort mid transfer ----
        wr(8'h10, 32'd10);
        wr(8'h00, 32'h3);
        xfer_ack = 1'b1;
        repeat (4) tick();
        wr(8'h00, 32'h4);            // ack on this cycle must be ignored
        xfer_ack = 1'b0;
        chk("abort_req", {31'h0, xfer_req}, 32'h0);
        rd_chk("abort_remain", 8'h18, 32'd6);
        rd_chk("abort_status", 8'h04, 32'h4);
        rd_chk("abort_intr", 8'h14, 32'h2);

        // ---- START with ABORT: no start ----
        wr(8'h00, 32'h5);
        chk("sa_no_start", {31'h0, xfer_req}, 32'h0);
        rd_chk("sa_status", 8'h04, 32'h4);

        // ---- reset while busy ----
        wr(8'h00, 32'h3);
        chk("busy_before_rst", {31'h0, xfer_req}, 32'h1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("rst_busy_req", {31'h0, xfer_req}, 32'h0);
        rd_chk("rst_busy_status", 8'h04, 32'h0);
        rd_chk("rst_busy_remain", 8'h18, 32'h0);
        rd_chk("rst_busy_intr", 8'h14, 32'h0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/dma_reg_file.md
Name: dma_reg_file

Overview:
Register bank and transfer-control engine on the DMA register bus, directly downstream of the bus interface (wdata/addr/wr_en/rd_en in, rdata out). It decodes register accesses and holds the channel configuration (source, destination, size). On software start it runs a transfer countdown paced by the datapath and reports status and interrupts. It is the DUT that the register-level UVM environment drives.

Parameters:
DATA_WIDTH, 32, width of the wdata/rdata bus and of all registers.
ADDR_WIDTH, 8, width of the register byte address.
SIZE_WIDTH, 16, width of the TRANS_SIZE and REMAIN counters (must be <= DATA_WIDTH).

Ports:
clk  in  1  single clock; all logic on posedge.
rst  in  1  synchronous, active-high reset.
wr_en  in  1  register write strobe, sampled on posedge.
rd_en  in  1  register read strobe, sampled on posedge.
addr  in  ADDR_WIDTH  register byte address; word aligned, addr[1:0] ignored.
wdata  in  DATA_WIDTH  write data.
rdata  out  DATA_WIDTH  registered read data.
xfer_ack  in  1  datapath accepted one beat this cycle.
xfer_req  out  1  high while the engine is BUSY.
src_addr_o  out  DATA_WIDTH  current SRC_ADDR value.
dst_addr_o  out  DATA_WIDTH  current DST_ADDR value.
irq  out  1  interrupt request, level.

Behaviour:
- Interface: one clock, clk. Reset rst is synchronous and active-high.
- Reset: all registers 0, FSM IDLE, rdata=0, xfer_req=0, irq=0. Reset in BUSY aborts immediately with no done or error flag.
- Register map (RW = read/write, RO = read-only, W1C = write 1 to clear):
  - 0x00 CTRL (RW): bit0 START (self-clearing, always reads 0), bit1 INTR_EN, bit2 ABORT (self-clearing, reads 0).
  - 0x04 STATUS (RO): bit0 BUSY, bit1 DONE, bit2 ERROR.
  - 0x08 SRC_ADDR (RW).
  - 0x0C DST_ADDR (RW).
  - 0x10 TRANS_SIZE (RW): bits[SIZE_WIDTH-1:0]; upper bits read 0.
  - 0x14 INTR_STAT (W1C): bit0 DONE_IRQ, bit1 ERR_IRQ.
  - 0x18 REMAIN (RO): remaining beat count.
- Unmapped addresses: reads return 0, writes are ignored. Writes to RO registers are ignored.
- Read timing: rdata updates on the posedge after rd_en is sampled (1-cycle latency) and holds its value when rd_en=0.
- Simultaneous wr_en and rd_en: both are performed. The read returns the pre-write value.
- Writes to SRC_ADDR, DST_ADDR and TRANS_SIZE while BUSY are ignored.
- FSM IDLE:
  - START with TRANS_SIZE != 0: REMAIN <= TRANS_SIZE, clear DONE and ERROR, go to BUSY.
  - START with TRANS_SIZE == 0: set ERROR and ERR_IRQ, stay in IDLE.
- FSM BUSY:
  - xfer_req=1.
  - Each cycle with xfer_ack=1: REMAIN decrements by 1.
  - If REMAIN==1 and xfer_ack=1: REMAIN <= 0, go to DONE.
  - ABORT: go to IDLE, set ERROR and ERR_IRQ, REMAIN holds its current value, the xfer_ack that cycle is ignored.
  - START: ignored.
- FSM DONE (1 cycle): set STATUS.DONE and DONE_IRQ, xfer_req=0, go to IDLE.
- BUSY bit = (state==BUSY).
- xfer_req drops on the cycle after the last ack.
- INTR_STAT: a hardware set and a W1C write to the same bit in the same cycle leave the bit set (set wins).
- irq = INTR_EN & (DONE_IRQ | ERR_IRQ), registered, 1 cycle after the contributing bit.
- src_addr_o and dst_addr_o mirror their registers combinationally.
- CTRL write with START=1 and ABORT=1 together: ABORT has priority and no start occurs.

Test Plan:
- Reset check: assert rst for 2 cycles, then read 0x00–0x18 -> all read 0; rdata=0, irq=0, xfer_req=0.
- Basic transfer:
  - Stimulus: write SRC=0x1000, DST=0x2000, SIZE=4, CTRL=0x3; xfer_ack held high.
  - Response: xfer_req high for exactly 4 cycles; REMAIN reads 3,2,1 during the transfer.
  - Afterwards: STATUS=0x2, INTR_STAT=0x1, irq=1.
  - Then write INTR_STAT=0x1 -> irq=0 two cycles later.
- Paced transfer and locked config:
  - Stimulus: SIZE=3, xfer_ack high on alternate cycles; write SIZE=9 while BUSY.
  - Response: DONE after the 3rd ack, not before; SIZE still reads 3.
- Zero size and abort:
  - START with SIZE=0 -> STATUS=0x4, ERR_IRQ=1, xfer_req never rises.
  - Start SIZE=10, ack 4 beats, write CTRL=0x4 -> IDLE, REMAIN=6, STATUS=0x4.
- Bus corners:
  - Read 0x3C -> 0.
  - Simultaneous write/read of SRC_ADDR (old 0x1000, new 0x5555) -> rdata=0x1000, next read 0x5555.
  - CTRL readback has START=0.
- W1C race: W1C DONE_IRQ in the same cycle the engine enters DONE -> DONE_IRQ remains 1.
